// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/imem/decode bundle; master drives flush,f_valid,f_pc,imem_rdata,out_ready, slave drives fetch_stall,out_valid,out_pc,out_instr,count
interface fetch_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic flush;
  logic f_valid;
  logic [16:0] f_pc;
  logic [31:0] imem_rdata;
  logic fetch_stall;
  logic out_valid;
  logic [16:0] out_pc;
  logic [31:0] out_instr;
  logic out_ready;
  logic [CW-1:0] count;
  modport master (
    output flush, f_valid, f_pc, imem_rdata, out_ready,
    input fetch_stall, out_valid, out_pc, out_instr, count
  );
  modport slave (
    input flush, f_valid, f_pc, imem_rdata, out_ready,
    output fetch_stall, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: aligns fetched PCs with next-cycle imem data and queues DEPTH pairs for decode; ports clk, reset (sync, active-high), bus (fetch_queue_if.slave)
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] NOP = 32'h00000013
) (
  input logic clk,
  input logic reset,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] FULL = (AW+2)'(DEPTH);
  logic [AW:0] cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pend_valid;
  logic [16:0] pend_pc;
  logic [16:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic valid, deq, take;
  logic [AW+1:0] fill;
  always_comb begin
    valid = cnt != '0;
    deq = valid & bus.out_ready;
    fill = {1'b0, cnt} + (AW+2)'(pend_valid) - (AW+2)'(deq);
    bus.fetch_stall = ~bus.flush & (fill >= FULL);
    take = bus.f_valid & ~bus.fetch_stall;
    bus.out_valid = valid;
    bus.out_pc = valid ? pc_mem[rd_ptr] : '0;
    bus.out_instr = valid ? instr_mem[rd_ptr] : NOP;
    bus.count = cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pend_valid <= 1'b0;
      pend_pc <= '0;
    end else begin
      pend_valid <= take;
      if (take) pend_pc <= bus.f_pc;
      if (bus.flush) begin
        cnt <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (pend_valid) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + (AW+1)'(pend_valid) - (AW+1)'(deq);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && pend_valid) begin
      pc_mem[wr_ptr] <= pend_pc;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct packed {logic [16:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fetch_queue_if #(.DEPTH(DEPTH)) bus();
  fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  ent_t q[$];
  bit m_pv;
  logic [16:0] m_ppc = '0;
  bit a_rs = 1'b1, a_fl, a_fv, a_rdy, a_st;
  logic [16:0] a_pc = '0;
  logic [53:0] exp_vec, obs;
  int checks, fails;
  assign obs = {bus.out_valid, bus.out_pc, bus.out_instr, bus.count, bus.fetch_stall};
  function automatic logic [31:0] imem_of(input logic [16:0] pc);
    return {pc[15:0], ~pc[16:1]} ^ 32'h5A5A3C3C;
  endfunction
  task automatic step(input bit rs, input bit fl, input bit fv, input logic [16:0] pc, input bit rdy);
    bit ev, st;
    int fill;
    ent_t h;
    @(posedge clk);
    if (a_rs) begin
      q.delete();
      m_pv = 1'b0;
      m_ppc = '0;
    end else if (a_fl) begin
      q.delete();
      m_pv = a_fv;
      if (a_fv) m_ppc = a_pc;
    end else begin
      if (q.size() != 0 && a_rdy) void'(q.pop_front());
      if (m_pv) q.push_back(ent_t'{m_ppc, imem_of(m_ppc)});
      m_pv = a_fv && !a_st;
      if (m_pv) m_ppc = a_pc;
    end
    @(negedge clk);
    reset = rs;
    bus.flush = fl;
    bus.f_valid = fv;
    bus.f_pc = pc;
    bus.out_ready = rdy;
    bus.imem_rdata = imem_of(a_pc);
    ev = q.size() != 0;
    h = ev ? q[0] : ent_t'{17'd0, NOP};
    fill = q.size() + int'(m_pv) - int'(ev && rdy);
    st = !fl && fill >= DEPTH;
    exp_vec = {ev, h.pc, h.instr, 3'(q.size()), st};
    a_rs = rs; a_fl = fl; a_fv = fv; a_pc = pc; a_rdy = rdy; a_st = st;
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(i < 2, 1'b0, i < 2, 17'(8 * i), 1'b0);
      checks++;
      if (obs !== {1'b0, 17'd0, NOP, 3'd0, 1'b0}) begin
        fails++;
        $display("FAIL reset i=%0d got=%h want=%h", i, obs, {1'b0, 17'd0, NOP, 3'd0, 1'b0});
      end
    end
  endtask
  task automatic test_streaming();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, i < 4, 17'(4 * i), 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL stream_model i=%0d got=%h want=%h", i, obs, exp_vec);
      end
      if (i >= 2 && i <= 5) begin
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 17'(4 * (i - 2)), imem_of(17'(4 * (i - 2)))}) begin
          fails++;
          $display("FAIL stream_head i=%0d got=%b/%h/%h want pc=%h", i, bus.out_valid, bus.out_pc, bus.out_instr, 4 * (i - 2));
        end
      end
      checks++;
      if (bus.count > 1) begin
        fails++;
        $display("FAIL stream_count i=%0d got=%0d want<=1", i, bus.count);
      end
    end
  endtask
  task automatic test_back_pressure();
    logic [16:0] pc = 17'h80, nxt = 17'h80;
    int got = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, pc, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL bp_model i=%0d got=%h want=%h", i, obs, exp_vec);
      end
      if (!bus.fetch_stall) pc += 17'd4;
    end
    checks++;
    if ({bus.count, bus.fetch_stall} !== {3'd4, 1'b1}) begin
      fails++;
      $display("FAIL bp_full got count=%0d stall=%b want 4/1", bus.count, bus.fetch_stall);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, i == 0, pc, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL bp_drain_model i=%0d got=%h want=%h", i, obs, exp_vec);
      end
      if (i == 0) begin
        checks++;
        if (bus.fetch_stall !== 1'b0) begin
          fails++;
          $display("FAIL bp_release_stall got=%b want=0", bus.fetch_stall);
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.out_pc !== nxt) begin
          fails++;
          $display("FAIL bp_order got=%h want=%h", bus.out_pc, nxt);
        end
        nxt += 17'd4;
        got++;
      end
    end
    checks++;
    if (got != 5) begin
      fails++;
      $display("FAIL bp_total got=%0d want=5", got);
    end
  endtask
  task automatic test_wrap();
    logic [16:0] pc = 17'h200, nxt = 17'h200;
    int got = 0;
    bit fv, rdy;
    for (int c = 0; c < 200 && got < 11; c++) begin
      fv = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      step(1'b0, 1'b0, fv, pc, rdy);
      checks++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL wrap_model c=%0d got=%h want=%h", c, obs, exp_vec);
      end
      if (bus.out_valid && rdy) begin
        checks++;
        if (bus.out_pc !== nxt || bus.out_instr !== imem_of(nxt)) begin
          fails++;
          $display("FAIL wrap_order got=%h/%h want=%h/%h", bus.out_pc, bus.out_instr, nxt, imem_of(nxt));
        end
        nxt += 17'd4;
        got++;
      end
      if (fv && !bus.fetch_stall) pc += 17'd4;
    end
    checks++;
    if (got != 11) begin
      fails++;
      $display("FAIL wrap_total got=%0d want=11", got);
    end
  endtask
  task automatic test_flush();
    step(1'b0, 1'b1, 1'b0, 17'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 17'(32'h40 + 4 * i), 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL flush_fill i=%0d got=%h want=%h", i, obs, exp_vec);
      end
    end
    step(1'b0, 1'b1, 1'b1, 17'h100, 1'b0);
    checks++;
    if ({bus.count, bus.fetch_stall} !== {3'd3, 1'b0}) begin
      fails++;
      $display("FAIL flush_cycle got count=%0d stall=%b want 3/0", bus.count, bus.fetch_stall);
    end
    step(1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.count} !== {1'b0, 3'd0}) begin
      fails++;
      $display("FAIL flush_cleared got valid=%b count=%0d want 0/0", bus.out_valid, bus.count);
    end
    step(1'b0, 1'b0, 1'b0, 17'd0, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 17'h100, imem_of(17'h100)}) begin
      fails++;
      $display("FAIL flush_target got=%b/%h/%h want 1/00100/%h", bus.out_valid, bus.out_pc, bus.out_instr, imem_of(17'h100));
    end
    step(1'b0, 1'b0, 1'b0, 17'd0, 1'b1);
    checks++;
    if (obs !== exp_vec) begin
      fails++;
      $display("FAIL flush_after got=%h want=%h", obs, exp_vec);
    end
  endtask
  task automatic test_flush_reset();
    logic [16:0] pc = 17'h280;
    step(1'b0, 1'b1, 1'b0, 17'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, pc, 1'b0);
      if (!bus.fetch_stall) pc += 17'd4;
    end
    checks++;
    if ({bus.count, bus.fetch_stall} !== {3'd4, 1'b1}) begin
      fails++;
      $display("FAIL fr_full got count=%0d stall=%b want 4/1", bus.count, bus.fetch_stall);
    end
    step(1'b0, 1'b1, 1'b1, 17'h300, 1'b0);
    checks++;
    if (bus.fetch_stall !== 1'b0) begin
      fails++;
      $display("FAIL fr_stalled_flush got stall=%b want 0", bus.fetch_stall);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 17'(32'h304 + 4 * i), 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL fr_model i=%0d got=%h want=%h", i, obs, exp_vec);
      end
    end
    step(1'b1, 1'b1, 1'b1, 17'h400, 1'b1);
    step(1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
    checks++;
    if (obs !== {1'b0, 17'd0, NOP, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL fr_reset got=%h want=%h", obs, {1'b0, 17'd0, NOP, 3'd0, 1'b0});
    end
    step(1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fr_pend_dropped got valid=%b want 0", bus.out_valid);
    end
  endtask
  task automatic test_random();
    logic [16:0] pc = 17'h1000;
    bit rs, fl, fv, rdy;
    for (int c = 0; c < 400; c++) begin
      rs = $urandom_range(0, 49) == 0;
      fl = $urandom_range(0, 14) == 0;
      fv = $urandom_range(0, 4) != 0;
      rdy = $urandom_range(0, 4) < 3;
      if (fl) pc = 17'($urandom) & 17'h1FFFC;
      step(rs, fl, fv, pc, rdy);
      checks++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL random_model c=%0d got=%h want=%h", c, obs, exp_vec);
      end
      if (fv && !bus.fetch_stall) pc += 17'd4;
    end
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.f_valid = 1'b0;
    bus.f_pc = '0;
    bus.imem_rdata = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_wrap();
    test_flush();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the fetch stage and decode. Fetch issues a 17-bit byte PC to the synchronous instruction memory each cycle, and the instruction word returns one cycle later. This block aligns each PC with its returning instruction, buffers up to DEPTH fetched pairs, and presents them in order to decode with a valid/ready handshake. It back-pressures fetch with `fetch_stall` and discards all in-flight and buffered work on a branch redirect (`flush`).

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- NOP, 32'h00000013: instruction driven on `out_instr` when the queue is empty
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  redirect (mispredict/jump); discards pending and queued entries
- f_valid  in  1  fetch is issuing address `f_pc` to instruction memory this cycle
- f_pc  in  17  byte PC of the issued fetch
- imem_rdata  in  32  instruction memory output; belongs to the PC issued the previous cycle
- fetch_stall  out  1  fetch must hold its PC and must not count this cycle's issue as accepted
- out_valid  out  1  head entry is valid
- out_pc  out  17  head PC; 0 when empty
- out_instr  out  32  head instruction; NOP when empty
- out_ready  in  1  decode consumes the head this cycle when `out_valid`
- count  out  log2(DEPTH)+1  number of queued entries

## Operation
- Pending slot (`pend_valid`, `pend_pc`):
  - Loaded when `f_valid & ~fetch_stall`; otherwise cleared.
  - The next cycle, if `pend_valid`, {`pend_pc`, `imem_rdata`} is written at the tail.
- Circular buffer of DEPTH entries, `wr_ptr`/`rd_ptr` of log2(DEPTH) bits, wrapping modulo DEPTH.
  - enq = `pend_valid`.
  - deq = `out_valid & out_ready`.
  - Simultaneous enq and deq: count unchanged, both pointers advance.
- `out_valid` = (count != 0); `out_pc`/`out_instr` read combinationally from `rd_ptr`. No bypass: a written entry is visible the cycle after the write.
- `fetch_stall` = ~flush & ((count + pend_valid − deq) ≥ DEPTH).
  - This includes same-cycle dequeue, so DEPTH=2 with `out_ready`=1 sustains one instruction per cycle.
  - Arithmetic is in log2(DEPTH)+2 bits; no underflow, since deq implies count ≥ 1.
- Flush, cycle-level:
  - count, `wr_ptr`, `rd_ptr` are reset to 0 next cycle.
  - The pending entry is dropped, not written. Its `imem_rdata` next cycle is ignored.
  - `fetch_stall` is 0 in the flush cycle. If `f_valid`, `f_pc` (the redirect target) is loaded into the pending slot, so the first post-flush instruction appears at `out_valid` 2 cycles after the flush cycle.
  - Any `out_ready` in the flush cycle has no architectural effect.
- Priority: reset > flush > normal enq/deq.
- Overflow cannot occur by construction. An enq into a full queue is an assertion failure in verification, not handled.

## Timing
- Reset values:
  - count=0, `pend_valid`=0, `pend_pc`=0, pointers 0.
  - `out_valid`=0, `out_pc`=0, `out_instr`=NOP, `fetch_stall`=0.
  - Queue storage is not reset.
- Reset asserted mid-operation: all of the above on the next edge. Pending data is lost and `imem_rdata` is ignored.
- Latency: issue at cycle N; enqueued at edge ending N+1; `out_valid` at N+2 (empty queue).
- Throughput: 1 instruction/cycle while `out_ready`=1.
- `fetch_stall` is combinational from count, `pend_valid`, `out_ready`, `flush`. There is no path from `f_valid`.
- Decode may deassert `out_ready` at any time; head outputs hold stable until consumed or flushed.

## Test plan
- Reset: hold reset 2 cycles with `f_valid`=1 -> `out_valid`=0, `out_instr`=32'h00000013, `out_pc`=0, count=0, `fetch_stall`=0.
- Streaming: `f_pc` 0,4,8,12 consecutive with matching `imem_rdata` A0..A3 one cycle later, `out_ready`=1 -> (0,A0) at cycle 2, then (4,A1), (8,A2), (12,A3) on consecutive cycles; count never exceeds 1.
- Back-pressure: `out_ready`=0 while issuing continuously with DEPTH=4 -> count reaches 4, `fetch_stall`=1 from the cycle count+pending reaches 4. No entry is lost or duplicated. Release `out_ready` -> drains in order and `fetch_stall` drops the same cycle as the first deq.
- Wrap-around: enqueue/dequeue 11 entries at DEPTH=4 with irregular `out_ready` -> strict FIFO order across pointer wrap.
- Flush: count=3 and pending valid, pulse flush with `f_valid`=1 and `f_pc`=0x100 -> next cycle count=0, `out_valid`=0. One cycle later (0x100, its instr) is at the head; the stale `imem_rdata` of the dropped pending entry never appears.
- Flush plus reset in the same cycle, and flush while stalled -> reset values; `fetch_stall`=0 in the flush cycle.
